// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file for the single-cycle RISC-V datapath.
// Sequential clear after reset, optional write-to-read bypass and hardwired zero entry.
module regfile_2w2r #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [AW-1:0]    ra0,
  output logic [WIDTH-1:0] rd0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1
);

  localparam int unsigned AWX = AW + 1;
  localparam logic [AW:0]   DEPTH_X   = AWX'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    clr_cnt, clr_cnt_n;
  logic             init_done_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic wv0_c, wv1_c;

  // An address names a real, writable/readable-from-storage entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wv0_c = (state == READY) && we0 && addr_ok(wa0);
  assign wv1_c = (state == READY) && we1 && addr_ok(wa1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      clr_cnt   <= clr_cnt_n;
      init_done <= init_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    init_done_n = init_done;
    case (state)
      CLEAR: begin
        clr_cnt_n = clr_cnt + AW'(1);
        if (clr_cnt == LAST_ADDR) begin
          state_n     = READY;
          clr_cnt_n   = '0;
          init_done_n = 1'b1;
        end
      end
      READY: begin
        state_n = READY;
      end
      default: begin
        state_n     = CLEAR;
        clr_cnt_n   = '0;
        init_done_n = 1'b0;
      end
    endcase
  end

  // Storage: clear one entry per cycle, then normal writes; port 1 is assigned last so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wv0_c) mem[wa0] <= wd0;
        if (wv1_c) mem[wa1] <= wd1;
      end
    end
  end

  // Read port A: bypass prefers the load writeback over the ALU writeback.
  always_comb begin
    rd0 = '0;
    if ((state == READY) && addr_ok(ra0)) begin
      if ((BYPASS != 0) && wv1_c && (wa1 == ra0))      rd0 = wd1;
      else if ((BYPASS != 0) && wv0_c && (wa0 == ra0)) rd0 = wd0;
      else                                             rd0 = mem[ra0];
    end
  end

  // Read port B: identical rules, independent address.
  always_comb begin
    rd1 = '0;
    if ((state == READY) && addr_ok(ra1)) begin
      if ((BYPASS != 0) && wv1_c && (wa1 == ra1))      rd1 = wd1;
      else if ((BYPASS != 0) && wv0_c && (wa0 == ra1)) rd1 = wd0;
      else                                             rd1 = mem[ra1];
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Scoreboard bench: two configurations of regfile_2w2r share one stimulus stream
// and are checked against an array-based reference model.
module tb_regfile_2w2r;

  logic        clk = 1'b0;
  logic        rst, we0, we1;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic        done_a, done_b;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;

  always #5 clk = ~clk;

  regfile_2w2r #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .init_done(done_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0_a), .ra1(ra1), .rd1(rd1_a));

  regfile_2w2r #(.WIDTH(32), .DEPTH(24), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .init_done(done_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0_b), .ra1(ra1), .rd1(rd1_b));

  typedef struct packed {
    logic [1:0]       done;
    logic [1:0][31:0] rd0;
    logic [1:0][31:0] rd1;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t stim_e;
  int   errors = 0;
  int   checks = 0;

  int          cfg_depth [2] = '{32, 24};
  bit          cfg_zero  [2] = '{1'b1, 1'b0};
  bit          cfg_byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mmem [2][32];
  bit          rdy  [2];
  int          left [2];

  function automatic bit wr_ok(input int i, input logic [4:0] a);
    return (int'(a) < cfg_depth[i]) && !(cfg_zero[i] && (a == 5'd0));
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] ra);
    if (!rdy[i] || !wr_ok(i, ra)) return 32'd0;
    if (cfg_byp[i]) begin
      if (we1 && wr_ok(i, wa1) && (wa1 == ra)) return wd1;
      if (we0 && wr_ok(i, wa0) && (wa0 == ra)) return wd0;
    end
    return mmem[i][ra];
  endfunction

  // Reference behaviour at a clock edge, from the currently applied inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rdy[i]  = 1'b0;
        left[i] = cfg_depth[i];
      end else if (!rdy[i]) begin
        left[i] = left[i] - 1;
        if (left[i] == 0) begin
          rdy[i] = 1'b1;
          for (int k = 0; k < 32; k++) mmem[i][k] = 32'd0;
        end
      end else begin
        if (we0 && wr_ok(i, wa0)) mmem[i][wa0] = wd0;
        if (we1 && wr_ok(i, wa1)) mmem[i][wa1] = wd1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, queue the expected outputs, then advance the model past the edge.
  task automatic cyc(input bit r, input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                     input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic [4:0] r0, input logic [4:0] r1);
    rst = r; we0 = w0; wa0 = a0; wd0 = d0; we1 = w1; wa1 = a1; wd1 = d1; ra0 = r0; ra1 = r1;
    #1;
    stim_e.done = {rdy[1], rdy[0]};
    for (int i = 0; i < 2; i++) begin
      stim_e.rd0[i] = exp_rd(i, ra0);
      stim_e.rd1[i] = exp_rd(i, ra1);
    end
    q.push_back(stim_e);
    @(posedge clk);
    model_edge();
    #2;
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] pool [6] = '{5'd0, 5'd5, 5'd7, 5'd23, 5'd24, 5'd30};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic rnd_cyc(input bit allow_rst);
    bit r;
    r = allow_rst && ($urandom_range(0, 399) == 0);
    cyc(r, 1'($urandom), pick_addr(), $urandom, 1'($urandom), pick_addr(), $urandom,
        pick_addr(), pick_addr());
  endtask

  // Monitor: compare every presented output against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("init_done_a", 32'(done_a), 32'(mon_e.done[0]));
        check("init_done_b", 32'(done_b), 32'(mon_e.done[1]));
        check("rd0_a", rd0_a, mon_e.rd0[0]);
        check("rd1_a", rd1_a, mon_e.rd1[0]);
        check("rd0_b", rd0_b, mon_e.rd0[1]);
        check("rd1_b", rd1_b, mon_e.rd1[1]);
      end
    end
  end

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; ra0 = '0; ra1 = '0; wd0 = '0; wd1 = '0;
    @(posedge clk);
    model_edge();
    #2;

    // Clear sequence with writes attempted while clearing.
    for (int c = 0; c < 34; c++) rnd_cyc(1'b0);

    // Same-cycle bypass versus next-cycle visibility.
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd5);

    // Port 1 wins on a same-address double write.
    cyc(0, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 5'd7, 5'd7);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0);

    // Write to entry 0.
    cyc(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Out-of-range address on the 24-entry file.
    cyc(0, 1, 5'd30, 32'h55, 0, 5'd0, 32'd0, 5'd30, 5'd30);
    cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd30, 5'd23);
    for (int a = 0; a < 32; a += 2)
      cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'(a), 5'(a + 1));

    // Reset restarted in the middle of a clear; old data must be gone.
    cyc(0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'h5A5A_0006, 5'd5, 5'd6);
    cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd6);
    for (int c = 0; c < 10; c++) rnd_cyc(1'b0);
    cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd6);
    for (int c = 0; c < 34; c++)
      cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd6);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) rnd_cyc(1'b1);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
